// File: rtl/acl_ram_arbiter.sv
// Shares one RAM port between the CPU dmem path and an accelerometer sample ring writer.
// Define ACL_ARB_STARVE_GUARD_EN to enable the starvation guard that briefly stalls the CPU.
module acl_ram_arbiter #(
  parameter logic [11:0] BUF_BASE     = 12'hF00,
  parameter int          BUF_DEPTH    = 64,
  parameter int          Q_DEPTH      = 4,
  parameter int          STARVE_LIMIT = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cpu_req,
  input  logic                         cpu_wren,
  input  logic [11:0]                  cpu_addr,
  input  logic [31:0]                  cpu_data,
  input  logic [14:0]                  acl_data,
  input  logic                         acl_strobe,
  input  logic                         ovf_clr,
  output logic                         ram_wren,
  output logic [11:0]                  ram_addr,
  output logic [31:0]                  ram_data,
  output logic [$clog2(BUF_DEPTH)-1:0] wr_ptr,
  output logic                         overflow,
  output logic                         cpu_stall,
  output logic [1:0]                   dbg_state
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int QA_W  = $clog2(Q_DEPTH);

  // Handshake: acl_strobe is a fire-and-forget push (no ready); a sample
  // offered while the queue is full and not popping is dropped and flagged.
  // The CPU path has no handshake beyond cpu_stall, which forces it to hold.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PEND  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [14:0]     q_mem [Q_DEPTH];
  logic [QA_W-1:0] q_rd;
  logic [QA_W-1:0] q_wr;
  logic [QA_W:0]   q_cnt;
  logic [QA_W:0]   q_cnt_next;
  logic [15:0]     seq;

  logic pending;
  logic full;
  logic pop;
  logic push;
  logic drop;
  logic stall;

  assign pending = (state != S_IDLE);
  assign full    = (q_cnt == (QA_W+1)'(Q_DEPTH));

`ifdef ACL_ARB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] starve_cnt;

  // Counts consecutive cycles the queue waits behind the CPU; cleared by any grant.
  always_ff @(posedge clock) begin
    if (reset || pop) begin
      starve_cnt <= '0;
    end else if (pending && cpu_req) begin
      starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  assign stall = !reset && pending && cpu_req && (starve_cnt == SC_W'(STARVE_LIMIT));
`else
  assign stall = 1'b0;
`endif

  assign cpu_stall = stall;
  assign pop  = !reset && pending && (!cpu_req || stall);
  // A full queue still accepts a sample in the same cycle it drains one.
  assign push = !reset && acl_strobe && (!full || pop);
  assign drop = !reset && acl_strobe && full && !pop;

  always_comb begin
    q_cnt_next = q_cnt;
    if (push && !pop) begin
      q_cnt_next = q_cnt + 1'b1;
    end else if (pop && !push) begin
      q_cnt_next = q_cnt - 1'b1;
    end
    state_next = (q_cnt_next == '0) ? S_IDLE : S_PEND;
  end

  always_comb begin
    ram_wren  = cpu_req & cpu_wren;
    ram_addr  = cpu_addr;
    ram_data  = cpu_data;
    dbg_state = state;
    if (pop) begin
      ram_wren  = 1'b1;
      ram_addr  = BUF_BASE + 12'(wr_ptr);
      ram_data  = {1'b0, seq, q_mem[q_rd]};
      dbg_state = S_WRITE;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_mem[q_wr] <= acl_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      q_rd     <= '0;
      q_wr     <= '0;
      q_cnt    <= '0;
      wr_ptr   <= '0;
      seq      <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      q_cnt <= q_cnt_next;
      if (push) begin
        q_wr <= q_wr + 1'b1;
      end
      // Ring index wraps naturally because BUF_DEPTH is a power of two.
      if (pop) begin
        q_rd   <= q_rd + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
        seq    <= seq + 16'd1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_acl_ram_arbiter.sv
// Directed bench for acl_ram_arbiter; expectations follow the guard macro setting.
module tb_acl_ram_arbiter;

`ifdef ACL_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        cpu_req;
  logic        cpu_wren;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_data;
  logic [14:0] acl_data;
  logic        acl_strobe;
  logic        ovf_clr;
  logic        ram_wren;
  logic [11:0] ram_addr;
  logic [31:0] ram_data;
  logic [5:0]  wr_ptr;
  logic        overflow;
  logic        cpu_stall;
  logic [1:0]  dbg_state;

  int n_pass;
  int n_total;

  acl_ram_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_wren   (cpu_wren),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .acl_data   (acl_data),
    .acl_strobe (acl_strobe),
    .ovf_clr    (ovf_clr),
    .ram_wren   (ram_wren),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .wr_ptr     (wr_ptr),
    .overflow   (overflow),
    .cpu_stall  (cpu_stall),
    .dbg_state  (dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic nedge();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    cpu_req = 1'b0;
    cpu_wren = 1'b0;
    cpu_addr = 12'h000;
    cpu_data = 32'h0;
    acl_data = 15'h0;
    acl_strobe = 1'b0;
    ovf_clr = 1'b0;
    cyc();

    // Reset state, CPU path live while reset is held
    cpu_req = 1'b1; cpu_wren = 1'b1; cpu_addr = 12'h0AB; cpu_data = 32'h12345678;
    nedge();
    chk("rst_cpu_wren", 32'(ram_wren), 32'd1);
    chk("rst_cpu_addr", 32'(ram_addr), 32'h0AB);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    cyc();

    // Idle port mirrors CPU address/data with write disabled
    reset = 1'b0; cpu_req = 1'b0; cpu_addr = 12'h123; cpu_data = 32'h0000DEAD;
    nedge();
    chk("idle_wren", 32'(ram_wren), 32'd0);
    chk("idle_addr", 32'(ram_addr), 32'h123);
    chk("idle_data", ram_data, 32'h0000DEAD);
    cyc();

    // Single strobe, free port: one-cycle latency
    acl_strobe = 1'b1; acl_data = 15'h1234;
    nedge();
    chk("lat_wren0", 32'(ram_wren), 32'd0);
    cyc();
    acl_strobe = 1'b0;
    nedge();
    chk("one_wren", 32'(ram_wren), 32'd1);
    chk("one_addr", 32'(ram_addr), 32'hF00);
    chk("one_data", ram_data, 32'h00001234);
    chk("one_state", 32'(dbg_state), 32'd2);
    cyc();
    nedge();
    chk("one_wr_ptr", 32'(wr_ptr), 32'd1);
    chk("one_done", 32'(ram_wren), 32'd0);
    cyc();

    // CPU holds port during 3 strobes, then queue drains in order
    do_reset();
    cpu_req = 1'b1; cpu_wren = 1'b1; cpu_addr = 12'h010; cpu_data = 32'h11111111;
    for (int k = 0; k < 3; k++) begin
      acl_strobe = 1'b1; acl_data = 15'(k + 1);
      nedge();
      chk("hold_wren", 32'(ram_wren), 32'd1);
      chk("hold_addr", 32'(ram_addr), 32'h010);
      chk("hold_data", ram_data, 32'h11111111);
      cyc();
    end
    acl_strobe = 1'b0;
    nedge();
    chk("hold_state", 32'(dbg_state), 32'd1);
    cyc();
    cpu_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nedge();
      chk("drain_wren", 32'(ram_wren), 32'd1);
      chk("drain_addr", 32'(ram_addr), 32'hF00 + 32'(k));
      chk("drain_data", ram_data, {1'b0, 16'(k), 15'(k + 1)});
      cyc();
    end
    nedge();
    chk("drain_end", 32'(ram_wren), 32'd0);
    chk("drain_ptr", 32'(wr_ptr), 32'd3);
    cyc();

    // Overflow: 5 strobes into 4 entries, set-wins, clear, then 4 writes
    do_reset();
    cpu_req = 1'b1; cpu_wren = 1'b1; cpu_addr = 12'h010; cpu_data = 32'hCAFE0000;
    for (int k = 0; k < 5; k++) begin
      acl_strobe = 1'b1; acl_data = 15'(32'h11 + k);
      nedge();
      chk("ovf_pre", 32'(overflow), 32'd0);
      chk("ovf_cpu_addr", 32'(ram_addr), 32'h010);
      cyc();
    end
    acl_strobe = 1'b0;
    nedge();
    chk("ovf_set", 32'(overflow), 32'd1);
    cyc();
    ovf_clr = 1'b1; acl_strobe = 1'b1; acl_data = 15'h7FFF;
    cyc();
    acl_strobe = 1'b0;
    nedge();
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    cyc();
    ovf_clr = 1'b0;
    nedge();
    chk("ovf_cleared", 32'(overflow), 32'd0);
    cyc();
    cpu_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      nedge();
      chk("ovf_drain_wren", 32'(ram_wren), 32'd1);
      chk("ovf_drain_addr", 32'(ram_addr), 32'hF00 + 32'(k));
      chk("ovf_drain_data", ram_data, {1'b0, 16'(k), 15'(32'h11 + k)});
      cyc();
    end
    nedge();
    chk("ovf_only4", 32'(ram_wren), 32'd0);
    chk("ovf_ptr", 32'(wr_ptr), 32'd4);
    cyc();

    // Push into a full queue that pops in the same cycle is accepted
    do_reset();
    cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 12'h040;
    for (int k = 0; k < 4; k++) begin
      acl_strobe = 1'b1; acl_data = 15'(32'h21 + k);
      cyc();
    end
    cpu_req = 1'b0; acl_data = 15'h0025;
    for (int k = 0; k < 5; k++) begin
      nedge();
      chk("fp_addr", 32'(ram_addr), 32'hF00 + 32'(k));
      chk("fp_data", ram_data, {1'b0, 16'(k), 15'(32'h21 + k)});
      cyc();
      acl_strobe = 1'b0;
    end
    nedge();
    chk("fp_no_ovf", 32'(overflow), 32'd0);
    chk("fp_end", 32'(ram_wren), 32'd0);
    cyc();

    // Ring wrap: 65 back-to-back samples
    do_reset();
    cpu_req = 1'b0;
    for (int k = 0; k < 65; k++) begin
      acl_strobe = 1'b1; acl_data = 15'(k);
      nedge();
      chk("ring_wren", 32'(ram_wren), 32'(k > 0));
      if (k > 0) begin
        chk("ring_addr", 32'(ram_addr), 32'hF00 + 32'((k - 1) % 64));
        chk("ring_data", ram_data, {1'b0, 16'(k - 1), 15'(k - 1)});
      end
      cyc();
    end
    acl_strobe = 1'b0;
    nedge();
    chk("wrap_addr", 32'(ram_addr), 32'hF00);
    chk("wrap_data", ram_data, 32'h00200040);
    cyc();
    nedge();
    chk("wrap_ptr", 32'(wr_ptr), 32'd1);
    cyc();

    // Starvation guard with CPU held
    do_reset();
    cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 12'h020; cpu_data = 32'h0;
    acl_strobe = 1'b1; acl_data = 15'h0077;
    nedge();
    chk("g_entry_stall", 32'(cpu_stall), 32'd0);
    cyc();
    acl_strobe = 1'b0;
    for (int j = 0; j < 16; j++) begin
      nedge();
      chk("g_hold_stall", 32'(cpu_stall), 32'd0);
      chk("g_hold_addr", 32'(ram_addr), 32'h020);
      cyc();
    end
    nedge();
    chk("g_stall", 32'(cpu_stall), 32'(GUARD));
    chk("g_wren", 32'(ram_wren), 32'(GUARD));
    chk("g_addr", 32'(ram_addr), GUARD ? 32'hF00 : 32'h020);
    cyc();
    nedge();
    chk("g_stall_once", 32'(cpu_stall), 32'd0);
    chk("g_state", 32'(dbg_state), GUARD ? 32'd0 : 32'd1);
    cyc();
    cpu_req = 1'b0;
    nedge();
    chk("g_rel_wren", 32'(ram_wren), GUARD ? 32'd0 : 32'd1);
    chk("g_rel_data", ram_data, GUARD ? 32'h0 : 32'h00000077);
    cyc();
    nedge();
    chk("g_ptr", 32'(wr_ptr), 32'd1);
    cyc();

    // Reset with 3 queued samples discards them
    do_reset();
    cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 12'h030;
    for (int k = 0; k < 3; k++) begin
      acl_strobe = 1'b1; acl_data = 15'(32'h40 + k);
      cyc();
    end
    acl_strobe = 1'b0; cpu_req = 1'b0; reset = 1'b1;
    nedge();
    chk("rq_no_write", 32'(ram_wren), 32'd0);
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nedge();
      chk("rq_quiet", 32'(ram_wren), 32'd0);
      cyc();
    end
    nedge();
    chk("rq_ptr", 32'(wr_ptr), 32'd0);
    chk("rq_ovf", 32'(overflow), 32'd0);
    chk("rq_state", 32'(dbg_state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/acl_ram_arbiter.md
ACL_RAM_ARBITER -- requirements
Module: acl_ram_arbiter

Interface
REQ-001 Parameter BUF_BASE, default 12'hF00: first RAM word of the accelerometer sample ring.
REQ-002 Parameter BUF_DEPTH, default 64: ring length in words; power of two, 2..256.
REQ-003 Parameter Q_DEPTH, default 4: pending-sample queue depth; power of two, 2..16.
REQ-004 Parameter STARVE_LIMIT, default 16: blocked-cycle threshold for the starvation guard.
REQ-005 Port: clock, input, 1, the single system clock; all state updates on its rising edge.
REQ-006 Port: reset, input, 1, synchronous, active-high reset.
REQ-007 Port: cpu_req, input, 1, processor is issuing a dmem access (load or store) this cycle.
REQ-008 Port: cpu_wren, input, 1, processor store enable.
REQ-009 Port: cpu_addr, input, 12, processor dmem word address.
REQ-010 Port: cpu_data, input, 32, processor store data.
REQ-011 Port: acl_data, input, 15, accelerometer sample {x[4:0], y[4:0], z[4:0]}, clock-domain synchronous.
REQ-012 Port: acl_strobe, input, 1, single-cycle pulse: acl_data holds a new sample.
REQ-013 Port: ovf_clr, input, 1, clears the overflow flag.
REQ-014 Port: ram_wren, output, 1, RAM write enable.
REQ-015 Port: ram_addr, output, 12, RAM address.
REQ-016 Port: ram_data, output, 32, RAM write data.
REQ-017 Port: wr_ptr, output, log2(BUF_DEPTH) bits, ring index of the next sample write.
REQ-018 Port: overflow, output, 1, sticky: a sample was dropped.
REQ-019 Port: cpu_stall, output, 1, processor must hold its access this cycle.

Function
REQ-020 Sample queue: FIFO of Q_DEPTH 15-bit entries; acl_strobe pushes acl_data when not full.
REQ-021 Arbiter states: IDLE (queue empty), PEND (queue non-empty, port held by CPU), WRITE (sampler owns port this cycle).
REQ-022 CPU path is combinational: when cpu_req=1 and cpu_stall=0, ram_wren/ram_addr/ram_data equal cpu_wren/cpu_addr/cpu_data in the same cycle.
REQ-023 Sampler write occurs in any cycle with queue non-empty and (cpu_req=0 or cpu_stall=1): ram_wren=1, ram_addr=BUF_BASE+wr_ptr, ram_data={1'b0, seq[15:0], head[14:0]}; queue pops, wr_ptr and seq increment at the clock edge.
REQ-024 Idle port (no CPU, queue empty): ram_wren=0, ram_addr=cpu_addr, ram_data=cpu_data.
REQ-025 wr_ptr wraps BUF_DEPTH-1 -> 0, ram_addr never leaves [BUF_BASE, BUF_BASE+BUF_DEPTH-1]; seq wraps 16'hFFFF -> 0.
REQ-026 Push while full: sample dropped, overflow set next cycle; push while full in a cycle that also pops: sample accepted, no overflow.
REQ-027 Push into empty queue while port free: sample enqueued, written earliest next cycle (one-cycle minimum latency strobe -> ram_wren).
REQ-028 ovf_clr and a concurrent drop in the same cycle: overflow remains 1 (set wins).
REQ-029 CPU accesses to the ring region are not blocked; the CPU may read and overwrite ring words.

Reset
REQ-030 reset=1 at a rising edge: queue emptied, state IDLE, wr_ptr=0, seq=0, overflow=0, starvation counter=0, cpu_stall=0.
REQ-031 Reset mid-operation discards queued samples; no sampler write issues in the reset cycle; CPU path remains combinational during reset.

Configuration
REQ-032 Macro ACL_ARB_STARVE_GUARD_EN defined: counter counts consecutive PEND cycles blocked by cpu_req; on reaching STARVE_LIMIT, cpu_stall=1 for exactly one cycle, sampler writes, counter clears.
REQ-033 Macro ACL_ARB_STARVE_GUARD_EN undefined: no counter, cpu_stall constant 0, CPU has absolute priority.

Verification
REQ-034 Reset, one strobe acl_data=15'h1234, cpu_req=0 -> next cycle ram_wren=1, ram_addr=12'hF00, ram_data=32'h00001234; wr_ptr=1.
REQ-035 cpu_req=1 held, cpu_wren=1, cpu_addr=12'h010, 3 strobes -> RAM sees only CPU writes to 12'h010; on cpu_req=0, three consecutive writes to F00,F01,F02 with seq 0,1,2.
REQ-036 cpu_req=1 held, 5 strobes with Q_DEPTH=4, guard off -> overflow=1 after 5th; ovf_clr -> overflow=0; release yields 4 writes only.
REQ-037 65 samples with port free -> 65th written at 12'hF00, wr_ptr=1, seq=64.
REQ-038 Guard on, cpu_req=1 held, 1 strobe -> cpu_stall=1 single cycle 16 cycles after PEND entry, sampler write that cycle; guard off -> cpu_stall never asserts.
REQ-039 Reset asserted with 3 queued samples -> no further sampler writes, wr_ptr=0, overflow=0.
